// File: rtl/memtouart_pkg.sv
// ============================================================================
//  Module   : memtouart_pkg
//  Brief    : Shared FSM state codes, ASCII constants and line lengths for
//             the memory-to-UART hex dumper.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package memtouart_pkg;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_READ  = 3'd1;
    localparam logic [2:0] c_S_CAPT  = 3'd2;
    localparam logic [2:0] c_S_SEND  = 3'd3;
    localparam logic [2:0] c_S_WAITB = 3'd4;
    localparam logic [2:0] c_S_FIN   = 3'd5;

    localparam logic [7:0] c_CH_CR    = 8'h0D;
    localparam logic [7:0] c_CH_LF    = 8'h0A;
    localparam logic [7:0] c_CH_COLON = 8'h3A;

    localparam logic [4:0] c_LINE_LEN      = 5'd10;
    localparam logic [4:0] c_LINE_LEN_ADDR = 5'd19;

endpackage

`default_nettype wire

// File: rtl/memtouart_if.sv
// ============================================================================
//  Module   : memtouart_if
//  Brief    : Start/status, memory read port and UART transmit bundle.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface memtouart_if;
    logic        start;
    logic [31:0] start_addr;
    logic        mem_r_en;
    logic [31:0] mem_r_addr;
    logic [31:0] mem_r_data;
    logic        uartbusy;
    logic [7:0]  charout;
    logic        uarttxen;
    logic        busy;
    logic        done;

    modport master (
        input  start, start_addr, mem_r_data, uartbusy,
        output mem_r_en, mem_r_addr, charout, uarttxen, busy, done
    );

    modport slave (
        output start, start_addr, mem_r_data, uartbusy,
        input  mem_r_en, mem_r_addr, charout, uarttxen, busy, done
    );
endinterface

`default_nettype wire

// File: rtl/memtouart_hexnib.sv
// ============================================================================
//  Module   : memtouart_hexnib
//  Brief    : 4-bit nibble to uppercase ASCII hex digit.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module memtouart_hexnib (
    input  wire logic [3:0] i_nib,
    output logic      [7:0] o_char
);
    // 0x37 + n lands on 'A' for n == 10
    always_comb begin
        if (i_nib < 4'd10) o_char = 8'h30 + {4'h0, i_nib};
        else               o_char = 8'h37 + {4'h0, i_nib};
    end
endmodule

`default_nettype wire

// File: rtl/memtouart.sv
// ============================================================================
//  Module   : memtouart
//  Brief    : Dumps WORDS memory words to the UART as hex lines.
//             MEMTOUART_ADDR_EN adds an "AAAAAAAA:" address prefix per line.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module memtouart
    import memtouart_pkg::*;
#(
    parameter int WORDS  = 16,
    parameter int STRIDE = 4
) (
    input  wire logic   clk,
    input  wire logic   rst,
    memtouart_if.master bus
);
`ifdef MEMTOUART_ADDR_EN
    localparam logic [4:0] c_LEN = c_LINE_LEN_ADDR;
`else
    localparam logic [4:0] c_LEN = c_LINE_LEN;
`endif

    logic [2:0]  r_state;
    logic [31:0] r_addr;
    logic [31:0] r_shift;
    logic [31:0] r_word;
    logic [31:0] r_mem_addr;
    logic [4:0]  r_idx;
    logic [7:0]  r_last;
    logic        r_mem_en;
    logic        r_busy;
    logic        r_done;
    logic        r_wait_first;

    logic        w_data_phase;
    logic [3:0]  w_nib;
    logic [7:0]  w_hex;
    logic [7:0]  w_char;

`ifdef MEMTOUART_ADDR_EN
    logic [31:0] w_addr_sh;
    assign w_addr_sh    = r_addr << {r_idx[2:0], 2'b00};
    assign w_data_phase = (r_idx > 5'd8) && (r_idx < 5'd17);
    assign w_nib        = (r_idx < 5'd8) ? w_addr_sh[31:28] : r_shift[31:28];
`else
    assign w_data_phase = (r_idx < 5'd8);
    assign w_nib        = r_shift[31:28];
`endif

    memtouart_hexnib u_hexnib (
        .i_nib  (w_nib),
        .o_char (w_hex)
    );

    always_comb begin
        w_char = w_hex;
        if (r_idx == c_LEN - 5'd2)      w_char = c_CH_CR;
        else if (r_idx == c_LEN - 5'd1) w_char = c_CH_LF;
`ifdef MEMTOUART_ADDR_EN
        else if (r_idx == 5'd8)         w_char = c_CH_COLON;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_S_IDLE;
            r_addr       <= '0;
            r_shift      <= '0;
            r_word       <= '0;
            r_idx        <= '0;
            r_last       <= '0;
            r_mem_en     <= 1'b0;
            r_mem_addr   <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wait_first <= 1'b0;
        end else begin
            r_mem_en   <= 1'b0;
            r_mem_addr <= '0;
            r_done     <= 1'b0;
            case (r_state)
                c_S_IDLE: if (bus.start) begin
                    r_addr     <= bus.start_addr;
                    r_word     <= '0;
                    r_busy     <= 1'b1;
                    r_mem_en   <= 1'b1;
                    r_mem_addr <= bus.start_addr;
                    r_state    <= c_S_READ;
                end
                c_S_READ: r_state <= c_S_CAPT;
                c_S_CAPT: begin
                    r_shift <= bus.mem_r_data;
                    r_idx   <= '0;
                    r_state <= c_S_SEND;
                end
                c_S_SEND: if (!bus.uartbusy) begin
                    r_last       <= w_char;
                    r_idx        <= r_idx + 5'd1;
                    if (w_data_phase) r_shift <= {r_shift[27:0], 4'h0};
                    r_wait_first <= 1'b1;
                    r_state      <= c_S_WAITB;
                end
                // First WAITB cycle is blind so the UART has time to raise busy
                c_S_WAITB: if (r_wait_first) begin
                    r_wait_first <= 1'b0;
                end else if (!bus.uartbusy) begin
                    if (r_idx != c_LEN) begin
                        r_state <= c_S_SEND;
                    end else if (r_word != 32'(WORDS - 1)) begin
                        r_word     <= r_word + 32'd1;
                        r_addr     <= r_addr + 32'(STRIDE);
                        r_mem_en   <= 1'b1;
                        r_mem_addr <= r_addr + 32'(STRIDE);
                        r_state    <= c_S_READ;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= c_S_FIN;
                    end
                end
                c_S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= c_S_IDLE;
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign bus.mem_r_en   = r_mem_en;
    assign bus.mem_r_addr = r_mem_addr;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.uarttxen   = (r_state == c_S_SEND) && !bus.uartbusy;
    assign bus.charout    = (r_state == c_S_SEND) ? w_char : r_last;

endmodule

`default_nettype wire

// File: tb/tb_memtouart.sv
// ============================================================================
//  Module   : tb_memtouart
//  Brief    : Scoreboard bench for memtouart (WORDS=1 and WORDS=3 instances).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_memtouart;
`ifdef MEMTOUART_ADDR_EN
    localparam int         LEN   = 19;
    localparam logic [7:0] FIRST = 8'h30;
`else
    localparam int         LEN   = 10;
    localparam logic [7:0] FIRST = 8'h44;
`endif

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   tx1 = 0, dn1 = 0, tx3 = 0, dn3 = 0;
    int   blen1 = 0, blen3 = 0;
    logic [3:0] cnt1, cnt3;

    logic [7:0]  q1[$];
    logic [7:0]  q3[$];
    logic [31:0] aq1[$];
    logic [31:0] aq3[$];

    memtouart_if b1();
    memtouart_if b3();

    memtouart #(.WORDS(1), .STRIDE(4)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.master));
    memtouart #(.WORDS(3), .STRIDE(4)) u_dut3 (.clk(clk), .rst(rst), .bus(b3.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_1000: return 32'hDEADBEEF;
            32'hFFFF_FFF8: return 32'hABCDEF01;
            32'hFFFF_FFFC: return 32'h89ABCDEF;
            32'h0000_0000: return 32'h01234567;
            32'h0000_2000: return 32'hCAFEF00D;
            32'h0000_2004: return 32'h13579BDF;
            32'h0000_2008: return 32'h2468ACE0;
            32'h0000_0010: return 32'h0000002A;
            default:       return 32'hFFFFFFFF;
        endcase
    endfunction

    always @(posedge clk) if (b1.mem_r_en) b1.mem_r_data <= mem_word(b1.mem_r_addr);
    always @(posedge clk) if (b3.mem_r_en) b3.mem_r_data <= mem_word(b3.mem_r_addr);

    // UART model: busy for blen cycles after each strobe
    always @(posedge clk) begin
        if (rst) cnt1 <= 4'd0;
        else if (b1.uarttxen && blen1 != 0) cnt1 <= 4'(blen1);
        else if (cnt1 != 0) cnt1 <= cnt1 - 4'd1;
    end
    always @(posedge clk) begin
        if (rst) cnt3 <= 4'd0;
        else if (b3.uarttxen && blen3 != 0) cnt3 <= 4'(blen3);
        else if (cnt3 != 0) cnt3 <= cnt3 - 4'd1;
    end
    assign b1.uartbusy = (cnt1 != 0);
    assign b3.uartbusy = (cnt3 != 0);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic push_line(input int which, input string pfx, input string dat);
        string s;
`ifdef MEMTOUART_ADDR_EN
        s = {pfx, ":", dat};
`else
        s = dat;
        if (pfx.len() != 8) $display("bad prefix literal %s", pfx);
`endif
        for (int i = 0; i < s.len(); i++) begin
            if (which == 1) q1.push_back(s[i]); else q3.push_back(s[i]);
        end
        if (which == 1) begin q1.push_back(8'h0D); q1.push_back(8'h0A); end
        else            begin q3.push_back(8'h0D); q3.push_back(8'h0A); end
    endtask

    // Monitors: an empty queue yields an expected value guaranteed to differ
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [7:0]  ec;
        if (b1.mem_r_en) begin
            ea = (aq1.size() != 0) ? aq1.pop_front() : ~b1.mem_r_addr;
            chk("addr1", b1.mem_r_addr, ea);
        end
        if (b1.uarttxen) begin
            tx1++;
            ec = (q1.size() != 0) ? q1.pop_front() : ~b1.charout;
            chk("char1", b1.charout, ec);
        end
        if (b1.done) dn1++;
    end
    always @(negedge clk) begin
        logic [31:0] ea;
        logic [7:0]  ec;
        if (b3.mem_r_en) begin
            ea = (aq3.size() != 0) ? aq3.pop_front() : ~b3.mem_r_addr;
            chk("addr3", b3.mem_r_addr, ea);
        end
        if (b3.uarttxen) begin
            tx3++;
            ec = (q3.size() != 0) ? q3.pop_front() : ~b3.charout;
            chk("char3", b3.charout, ec);
        end
        if (b3.done) dn3++;
    end

    task automatic kick(input int which, input logic [31:0] a);
        @(negedge clk);
        if (which == 1) begin b1.start = 1'b1; b1.start_addr = a; end
        else            begin b3.start = 1'b1; b3.start_addr = a; end
        @(negedge clk);
        b1.start = 1'b0;
        b3.start = 1'b0;
    endtask

    task automatic wait_done(input int which, input string nm);
        int n = 0;
        while (n < 3000 && !((which == 1) ? b1.done : b3.done)) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_timeout"}, 64'(n < 3000), 64'd1);
        @(negedge clk);
    endtask

    initial begin
        int t0, d0, k, n, drop;
        rst = 1'b1;
        b1.start = 1'b0; b1.start_addr = '0;
        b3.start = 1'b0; b3.start_addr = '0;
        repeat (3) @(negedge clk);
        chk("reset1", {b1.busy, b1.done, b1.mem_r_en, b1.uarttxen, b1.charout, b1.mem_r_addr}, 64'd0);
        chk("reset3", {b3.busy, b3.done, b3.mem_r_en, b3.uarttxen, b3.charout, b3.mem_r_addr}, 64'd0);
        rst = 1'b0;

        // single word, slow UART
        blen1 = 3;
        push_line(1, "00001000", "DEADBEEF");
        aq1.push_back(32'h0000_1000);
        t0 = tx1; d0 = dn1;
        kick(1, 32'h0000_1000);
        wait_done(1, "t1");
        chk("t1_txen", 64'(tx1 - t0), 64'(LEN));
        chk("t1_done", 64'(dn1 - d0), 64'd1);
        chk("t1_busy_after", b1.busy, 1'b0);

        // latency, UART never busy
        blen1 = 0;
        push_line(1, "00001000", "DEADBEEF");
        aq1.push_back(32'h0000_1000);
        @(negedge clk);
        b1.start = 1'b1; b1.start_addr = 32'h0000_1000;
        @(negedge clk);
        b1.start = 1'b0;
        chk("t2_c1_en", b1.mem_r_en, 1'b1);
        chk("t2_c1_addr", b1.mem_r_addr, 32'h0000_1000);
        chk("t2_c1_busy", b1.busy, 1'b1);
        @(negedge clk);
        chk("t2_c2_txen", b1.uarttxen, 1'b0);
        @(negedge clk);
        chk("t2_c3_txen", b1.uarttxen, 1'b1);
        chk("t2_c3_char", b1.charout, FIRST);
        wait_done(1, "t2");

        // three words wrapping through zero
        blen3 = 1;
        aq3.push_back(32'hFFFF_FFF8);
        aq3.push_back(32'hFFFF_FFFC);
        aq3.push_back(32'h0000_0000);
        push_line(3, "FFFFFFF8", "ABCDEF01");
        push_line(3, "FFFFFFFC", "89ABCDEF");
        push_line(3, "00000000", "01234567");
        t0 = tx3; d0 = dn3;
        kick(3, 32'hFFFF_FFF8);
        wait_done(3, "t3");
        chk("t3_txen", 64'(tx3 - t0), 64'(3 * LEN));
        chk("t3_done", 64'(dn3 - d0), 64'd1);

        // second start mid-dump must be ignored
        blen3 = 2;
        aq3.push_back(32'h0000_2000);
        aq3.push_back(32'h0000_2004);
        aq3.push_back(32'h0000_2008);
        push_line(3, "00002000", "CAFEF00D");
        push_line(3, "00002004", "13579BDF");
        push_line(3, "00002008", "2468ACE0");
        t0 = tx3; d0 = dn3; drop = 0;
        kick(3, 32'h0000_2000);
        n = 0;
        while (n < 3000 && !b3.done) begin
            if (!b3.busy) drop++;
            @(negedge clk);
            n++;
            if (n == 40) begin b3.start = 1'b1; b3.start_addr = 32'h0000_5000; end
            if (n == 41) b3.start = 1'b0;
        end
        chk("t4_timeout", 64'(n < 3000), 64'd1);
        chk("t4_busy_held", 64'(drop), 64'd0);
        repeat (30) @(negedge clk);
        chk("t4_txen", 64'(tx3 - t0), 64'(3 * LEN));
        chk("t4_done", 64'(dn3 - d0), 64'd1);
        chk("t4_idle", b3.busy, 1'b0);

        // reset after the fourth char, then a fresh dump
        blen1 = 3;
        push_line(1, "00001000", "DEADBEEF");
        aq1.push_back(32'h0000_1000);
        kick(1, 32'h0000_1000);
        k = 0; n = 0;
        while (k < 4 && n < 2000) begin
            @(negedge clk);
            n++;
            if (b1.uarttxen) k++;
        end
        chk("t5_four_chars", 64'(k), 64'd4);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_reset_outs", {b1.busy, b1.done, b1.mem_r_en, b1.uarttxen, b1.charout, b1.mem_r_addr}, 64'd0);
        rst = 1'b0;
        q1.delete();
        aq1.delete();
        push_line(1, "00002000", "CAFEF00D");
        aq1.push_back(32'h0000_2000);
        t0 = tx1; d0 = dn1;
        kick(1, 32'h0000_2000);
        wait_done(1, "t5");
        chk("t5_txen", 64'(tx1 - t0), 64'(LEN));
        chk("t5_done", 64'(dn1 - d0), 64'd1);

        // small value, leading zero digits (and address prefix when enabled)
        blen1 = 1;
        push_line(1, "00000010", "0000002A");
        aq1.push_back(32'h0000_0010);
        t0 = tx1;
        kick(1, 32'h0000_0010);
        wait_done(1, "t6");
        chk("t6_txen", 64'(tx1 - t0), 64'(LEN));

        repeat (5) @(negedge clk);
        chk("q1_drained", 64'(q1.size() + aq1.size()), 64'd0);
        chk("q3_drained", 64'(q3.size() + aq3.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

`default_nettype wire
